// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation encodings and ex_ctrl layout.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10,
    ALU_AUIPC  = 4'd11,
    ALU_LINK   = 4'd12
  } alu_op_t;

  // Field order defines the packed ex_ctrl bus, MSB first.
  typedef struct packed {
    alu_op_t    alu_op;
    logic       alu_src_imm;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       branch;
    logic       jump;
    logic [2:0] funct3;
  } ctrl_t;

  localparam int unsigned CTRL_W           = 13;
  localparam int unsigned CTRL_ALU_OP_LSB  = 9;
  localparam int unsigned CTRL_ALU_SRC_IMM = 8;
  localparam int unsigned CTRL_MEM_READ    = 7;
  localparam int unsigned CTRL_MEM_WRITE   = 6;
  localparam int unsigned CTRL_REG_WRITE   = 5;
  localparam int unsigned CTRL_BRANCH      = 4;
  localparam int unsigned CTRL_JUMP        = 3;
  localparam int unsigned CTRL_FUNCT3_LSB  = 0;

  // alt selects SUB/SRA; callers only set it where the ISA allows.
  function automatic alu_op_t alu_op_from_funct(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// RV32I immediate generator: selects I/S/B/U/J format from the opcode, sign-extends to 32 bits.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (instr[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR:
        imm = {{20{instr[31]}}, instr[31:20]};
      OPC_STORE:
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH:
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm = {instr[31:12], 12'h000};
      OPC_JAL:
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID register, decode, load-use / writeback hazard stall, ID/EX register.
// Build option DECODE_WB_BYPASS_EN forwards the writeback port into operand reads instead of stalling.
module decode_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instr,
  output logic        id_stall,
  input  logic        ex_flush,
  output logic [4:0]  rf_read_addr_1,
  output logic [4:0]  rf_read_addr_2,
  input  logic [31:0] rf_data_1,
  input  logic [31:0] rf_data_2,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_write_addr,
  input  logic [31:0] wb_write_data,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs1_val,
  output logic [31:0] ex_rs2_val,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [4:0]  ex_rd,
  output logic [12:0] ex_ctrl
);

  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;

  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3;
  logic        legal, rs1_used, rs2_used, dec_valid;
  ctrl_t       dec_ctrl;
  ctrl_t       ex_ctrl_r;
  logic [31:0] dec_imm;
  logic [31:0] rs1_val, rs2_val;
  logic        rs1_hit_wb, rs2_hit_wb;
  logic        load_use, wb_hazard;

  assign opcode = ifid_instr[6:0];
  assign rd     = ifid_instr[11:7];
  assign funct3 = ifid_instr[14:12];
  assign rs1    = ifid_instr[19:15];
  assign rs2    = ifid_instr[24:20];

  assign rf_read_addr_1 = reset ? NOP_INSTR[19:15] : rs1;
  assign rf_read_addr_2 = reset ? NOP_INSTR[24:20] : rs2;

  always_ff @(posedge clk) begin
    if (reset || ex_flush) begin
      ifid_valid <= 1'b0;
      ifid_pc    <= '0;
      ifid_instr <= NOP_INSTR;
    end else if (!id_stall) begin
      ifid_valid <= if_valid;
      ifid_pc    <= if_pc;
      ifid_instr <= if_instr;
    end
  end

  always_comb begin
    legal    = 1'b0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    dec_ctrl = '0;
    case (opcode)
      OPC_LUI: begin
        legal = 1'b1;
        dec_ctrl.alu_op = ALU_PASS_B;
        dec_ctrl.alu_src_imm = 1'b1;
        dec_ctrl.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        legal = 1'b1;
        dec_ctrl.alu_op = ALU_AUIPC;
        dec_ctrl.alu_src_imm = 1'b1;
        dec_ctrl.reg_write = 1'b1;
      end
      OPC_JAL: begin
        legal = 1'b1;
        dec_ctrl.alu_op = ALU_LINK;
        dec_ctrl.alu_src_imm = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.jump = 1'b1;
      end
      OPC_JALR: begin
        legal = 1'b1;
        rs1_used = 1'b1;
        dec_ctrl.alu_op = ALU_LINK;
        dec_ctrl.alu_src_imm = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.jump = 1'b1;
        dec_ctrl.funct3 = funct3;
      end
      OPC_BRANCH: begin
        legal = 1'b1;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        dec_ctrl.alu_op = ALU_SUB;
        dec_ctrl.branch = 1'b1;
        dec_ctrl.funct3 = funct3;
      end
      OPC_LOAD: begin
        legal = 1'b1;
        rs1_used = 1'b1;
        dec_ctrl.alu_op = ALU_ADD;
        dec_ctrl.alu_src_imm = 1'b1;
        dec_ctrl.mem_read = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.funct3 = funct3;
      end
      OPC_STORE: begin
        legal = 1'b1;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        dec_ctrl.alu_op = ALU_ADD;
        dec_ctrl.alu_src_imm = 1'b1;
        dec_ctrl.mem_write = 1'b1;
        dec_ctrl.funct3 = funct3;
      end
      OPC_OP_IMM: begin
        legal = 1'b1;
        rs1_used = 1'b1;
        dec_ctrl.alu_op = alu_op_from_funct(funct3, (funct3 == 3'b101) && ifid_instr[30]);
        dec_ctrl.alu_src_imm = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.funct3 = funct3;
      end
      OPC_OP: begin
        legal = 1'b1;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        dec_ctrl.alu_op = alu_op_from_funct(funct3, ifid_instr[30]);
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.funct3 = funct3;
      end
      default: ;
    endcase
    if (rd == 5'd0)
      dec_ctrl.reg_write = 1'b0;
  end

  assign dec_valid = ifid_valid && legal;

  imm_gen u_imm_gen (
    .instr (ifid_instr),
    .imm   (dec_imm)
  );

  assign rs1_hit_wb = wb_reg_write && (wb_write_addr != 5'd0) && rs1_used && (wb_write_addr == rs1);
  assign rs2_hit_wb = wb_reg_write && (wb_write_addr != 5'd0) && rs2_used && (wb_write_addr == rs2);

`ifdef DECODE_WB_BYPASS_EN
  assign wb_hazard = 1'b0;
  assign rs1_val = (!rs1_used || rs1 == 5'd0) ? '0 : (rs1_hit_wb ? wb_write_data : rf_data_1);
  assign rs2_val = (!rs2_used || rs2 == 5'd0) ? '0 : (rs2_hit_wb ? wb_write_data : rf_data_2);
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_write_data;
  // Register file is written at this edge; stalling once lets the next cycle read the new value.
  assign wb_hazard = rs1_hit_wb || rs2_hit_wb;
  assign rs1_val = (!rs1_used || rs1 == 5'd0) ? '0 : rf_data_1;
  assign rs2_val = (!rs2_used || rs2 == 5'd0) ? '0 : rf_data_2;
`endif

  assign load_use = ex_valid && ex_ctrl_r.mem_read && (ex_rd != 5'd0) &&
                    ((rs1_used && ex_rd == rs1) || (rs2_used && ex_rd == rs2));

  assign id_stall = !reset && !ex_flush && dec_valid && (load_use || wb_hazard);

  always_ff @(posedge clk) begin
    if (reset || ex_flush || id_stall || !dec_valid) begin
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      ex_rs1_val <= '0;
      ex_rs2_val <= '0;
      ex_imm     <= '0;
      ex_rs1     <= '0;
      ex_rs2     <= '0;
      ex_rd      <= '0;
      ex_ctrl_r  <= '0;
    end else begin
      ex_valid   <= 1'b1;
      ex_pc      <= ifid_pc;
      ex_rs1_val <= rs1_val;
      ex_rs2_val <= rs2_val;
      ex_imm     <= dec_imm;
      ex_rs1     <= rs1_used ? rs1 : 5'd0;
      ex_rs2     <= rs2_used ? rs2 : 5'd0;
      ex_rd      <= dec_ctrl.reg_write ? rd : 5'd0;
      ex_ctrl_r  <= dec_ctrl;
    end
  end

  assign ex_ctrl = ex_ctrl_r;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; follows DECODE_WB_BYPASS_EN for the writeback case.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        id_stall;
  logic        ex_flush;
  logic [4:0]  rf_read_addr_1, rf_read_addr_2;
  logic [31:0] rf_data_1, rf_data_2;
  logic        wb_reg_write;
  logic [4:0]  wb_write_addr;
  logic [31:0] wb_write_data;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [12:0] ex_ctrl;

  int passed = 0;
  int total  = 0;

  localparam logic [31:0] I_ADDI_X5   = 32'h0070_0293;
  localparam logic [31:0] I_LW_X6     = 32'h0002_A303;
  localparam logic [31:0] I_ADD_X7    = 32'h0063_03B3;
  localparam logic [31:0] I_BEQ       = 32'h0020_8463;
  localparam logic [31:0] I_SW        = 32'hFE00_2E23;
  localparam logic [31:0] I_JAL       = 32'hFF9F_F06F;
  localparam logic [31:0] I_BAD       = 32'h0000_007F;
  localparam logic [31:0] I_ADDI_X9   = 32'h0004_8513;

  always #5 clk = ~clk;

  decode_stage #(.NOP_INSTR(32'h0000_0013)) dut (
    .clk            (clk),
    .reset          (reset),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .id_stall       (id_stall),
    .ex_flush       (ex_flush),
    .rf_read_addr_1 (rf_read_addr_1),
    .rf_read_addr_2 (rf_read_addr_2),
    .rf_data_1      (rf_data_1),
    .rf_data_2      (rf_data_2),
    .wb_reg_write   (wb_reg_write),
    .wb_write_addr  (wb_write_addr),
    .wb_write_data  (wb_write_data),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_rs1_val     (ex_rs1_val),
    .ex_rs2_val     (ex_rs2_val),
    .ex_imm         (ex_imm),
    .ex_rs1         (ex_rs1),
    .ex_rs2         (ex_rs2),
    .ex_rd          (ex_rd),
    .ex_ctrl        (ex_ctrl)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic v, input logic [31:0] pc, input logic [31:0] instr);
    if_valid = v;
    if_pc    = pc;
    if_instr = instr;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    fetch(1'b0, 32'h0, 32'h0);
    ex_flush = 1'b0;
    rf_data_1 = 32'h1234_5678;
    rf_data_2 = 32'h9ABC_DEF0;
    wb_reg_write = 1'b0;
    wb_write_addr = 5'd0;
    wb_write_data = 32'h0;
    repeat (3) tick();
    total++; if (ex_valid !== 1'b0) $display("FAIL reset_ex_valid got=%b want=0", ex_valid); else passed++;
    total++; if (ex_ctrl !== 13'h0) $display("FAIL reset_ex_ctrl got=%h want=0", ex_ctrl); else passed++;
    total++; if ({ex_pc, ex_imm, ex_rs1_val, ex_rs2_val} !== 128'h0)
      $display("FAIL reset_ex_data got=%h want=0", {ex_pc, ex_imm, ex_rs1_val, ex_rs2_val}); else passed++;
    total++; if (id_stall !== 1'b0) $display("FAIL reset_id_stall got=%b want=0", id_stall); else passed++;
    total++; if ({rf_read_addr_1, rf_read_addr_2} !== 10'h0)
      $display("FAIL reset_rf_addr got=%h want=0", {rf_read_addr_1, rf_read_addr_2}); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_addi;
    fetch(1'b1, 32'h10, I_ADDI_X5);
    tick();
    fetch(1'b0, 32'h0, 32'h0);
    tick();
    total++; if (ex_valid !== 1'b1) $display("FAIL addi_valid got=%b want=1", ex_valid); else passed++;
    total++; if (ex_imm !== 32'd7) $display("FAIL addi_imm got=%h want=7", ex_imm); else passed++;
    total++; if (ex_rd !== 5'd5) $display("FAIL addi_rd got=%0d want=5", ex_rd); else passed++;
    total++; if (ex_ctrl !== 13'h120) $display("FAIL addi_ctrl got=%h want=120", ex_ctrl); else passed++;
    total++; if (ex_pc !== 32'h10) $display("FAIL addi_pc got=%h want=10", ex_pc); else passed++;
    total++; if (ex_rs1_val !== 32'h0) $display("FAIL addi_x0_read got=%h want=0", ex_rs1_val); else passed++;
    tick();
  endtask

  task automatic test_load_use;
    rf_data_1 = 32'h11;
    rf_data_2 = 32'h22;
    fetch(1'b1, 32'h20, I_LW_X6);
    tick();
    fetch(1'b1, 32'h24, I_ADD_X7);
    #1;
    total++; if (id_stall !== 1'b0) $display("FAIL lu_no_stall_first got=%b want=0", id_stall); else passed++;
    tick();
    total++; if (id_stall !== 1'b1) $display("FAIL lu_stall got=%b want=1", id_stall); else passed++;
    total++; if (ex_valid !== 1'b1 || ex_ctrl[7] !== 1'b1 || ex_rd !== 5'd6)
      $display("FAIL lu_load_in_ex got=%b/%b/%0d want=1/1/6", ex_valid, ex_ctrl[7], ex_rd); else passed++;
    fetch(1'b0, 32'h0, 32'h0);
    tick();
    total++; if (ex_valid !== 1'b0) $display("FAIL lu_bubble got=%b want=0", ex_valid); else passed++;
    total++; if (id_stall !== 1'b0) $display("FAIL lu_stall_released got=%b want=0", id_stall); else passed++;
    tick();
    total++; if (ex_valid !== 1'b1 || ex_pc !== 32'h24 || ex_rd !== 5'd7)
      $display("FAIL lu_add_in_ex got=%b/%h/%0d want=1/24/7", ex_valid, ex_pc, ex_rd); else passed++;
    total++; if ({ex_rs1, ex_rs2} !== {5'd6, 5'd6} || ex_rs1_val !== 32'h11 || ex_rs2_val !== 32'h22)
      $display("FAIL lu_add_operands got=%0d,%0d,%h,%h want=6,6,11,22", ex_rs1, ex_rs2, ex_rs1_val, ex_rs2_val);
    else passed++;
    tick();
  endtask

  task automatic test_flush;
    fetch(1'b1, 32'h30, I_BEQ);
    tick();
    total++; if ({rf_read_addr_1, rf_read_addr_2} !== {5'd1, 5'd2})
      $display("FAIL fl_beq_addr got=%0d,%0d want=1,2", rf_read_addr_1, rf_read_addr_2); else passed++;
    fetch(1'b1, 32'h34, I_ADDI_X5);
    ex_flush = 1'b1;
    tick();
    ex_flush = 1'b0;
    fetch(1'b0, 32'h0, 32'h0);
    total++; if (ex_valid !== 1'b0) $display("FAIL fl_ex_bubble got=%b want=0", ex_valid); else passed++;
    total++; if ({rf_read_addr_1, rf_read_addr_2} !== 10'h0)
      $display("FAIL fl_ifid_empty got=%h want=0", {rf_read_addr_1, rf_read_addr_2}); else passed++;
    tick();
    total++; if (ex_valid !== 1'b0) $display("FAIL fl_no_late_issue got=%b want=0", ex_valid); else passed++;

    fetch(1'b1, 32'h40, I_LW_X6);
    tick();
    fetch(1'b1, 32'h44, I_ADD_X7);
    tick();
    total++; if (id_stall !== 1'b1) $display("FAIL fl_stall_setup got=%b want=1", id_stall); else passed++;
    ex_flush = 1'b1;
    #1;
    total++; if (id_stall !== 1'b0) $display("FAIL fl_flush_beats_stall got=%b want=0", id_stall); else passed++;
    tick();
    ex_flush = 1'b0;
    fetch(1'b0, 32'h0, 32'h0);
    total++; if (ex_valid !== 1'b0 || rf_read_addr_1 !== 5'd0)
      $display("FAIL fl_after_stall got=%b/%0d want=0/0", ex_valid, rf_read_addr_1); else passed++;
    tick();

    fetch(1'b1, 32'h50, I_LW_X6);
    tick();
    fetch(1'b1, 32'h54, I_ADD_X7);
    tick();
    reset = 1'b1;
    #1;
    total++; if (id_stall !== 1'b0) $display("FAIL rst_cancels_stall got=%b want=0", id_stall); else passed++;
    tick();
    reset = 1'b0;
    fetch(1'b0, 32'h0, 32'h0);
    total++; if (ex_valid !== 1'b0 || ex_ctrl !== 13'h0)
      $display("FAIL rst_mid_stall_ex got=%b/%h want=0/0", ex_valid, ex_ctrl); else passed++;
    tick();
  endtask

  task automatic test_wb_hazard;
    fetch(1'b1, 32'h60, I_ADDI_X9);
    tick();
    fetch(1'b0, 32'h0, 32'h0);
    wb_reg_write = 1'b1;
    wb_write_addr = 5'd9;
    wb_write_data = 32'hDEAD_BEEF;
    rf_data_1 = 32'h0BAD_F00D;
    #1;
`ifdef DECODE_WB_BYPASS_EN
    total++; if (id_stall !== 1'b0) $display("FAIL wb_bypass_no_stall got=%b want=0", id_stall); else passed++;
    tick();
    wb_reg_write = 1'b0;
    rf_data_1 = 32'hDEAD_BEEF;
    total++; if (ex_valid !== 1'b1 || ex_rs1_val !== 32'hDEAD_BEEF)
      $display("FAIL wb_bypass_value got=%b/%h want=1/deadbeef", ex_valid, ex_rs1_val); else passed++;
`else
    total++; if (id_stall !== 1'b1) $display("FAIL wb_stall got=%b want=1", id_stall); else passed++;
    tick();
    wb_reg_write = 1'b0;
    rf_data_1 = 32'hDEAD_BEEF;
    #1;
    total++; if (ex_valid !== 1'b0 || id_stall !== 1'b0)
      $display("FAIL wb_bubble got=%b/%b want=0/0", ex_valid, id_stall); else passed++;
    tick();
    total++; if (ex_valid !== 1'b1 || ex_rs1_val !== 32'hDEAD_BEEF)
      $display("FAIL wb_reread_value got=%b/%h want=1/deadbeef", ex_valid, ex_rs1_val); else passed++;
`endif
    tick();
  endtask

  task automatic test_imm_bounds;
    fetch(1'b1, 32'h70, I_SW);
    tick();
    fetch(1'b1, 32'h74, I_JAL);
    tick();
    total++; if (ex_valid !== 1'b1 || ex_imm !== 32'hFFFF_FFFC)
      $display("FAIL sw_imm got=%b/%h want=1/fffffffc", ex_valid, ex_imm); else passed++;
    total++; if (ex_ctrl[5] !== 1'b0 || ex_ctrl[6] !== 1'b1 || ex_rd !== 5'd0)
      $display("FAIL sw_ctrl got=rw%b mw%b rd%0d want=rw0 mw1 rd0", ex_ctrl[5], ex_ctrl[6], ex_rd); else passed++;
    fetch(1'b1, 32'h78, I_BAD);
    tick();
    total++; if (ex_valid !== 1'b1 || ex_imm !== 32'hFFFF_FFF8)
      $display("FAIL jal_imm got=%b/%h want=1/fffffff8", ex_valid, ex_imm); else passed++;
    total++; if (ex_ctrl[5] !== 1'b0 || ex_ctrl[3] !== 1'b1 || ex_rd !== 5'd0)
      $display("FAIL jal_ctrl got=rw%b j%b rd%0d want=rw0 j1 rd0", ex_ctrl[5], ex_ctrl[3], ex_rd); else passed++;
    fetch(1'b0, 32'h0, 32'h0);
    tick();
    total++; if (ex_valid !== 1'b0 || ex_ctrl !== 13'h0)
      $display("FAIL bad_opcode_bubble got=%b/%h want=0/0", ex_valid, ex_ctrl); else passed++;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_use();
    test_flush();
    test_wb_hazard();
    test_imm_bounds();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
